// File: rtl/id_ex_stage_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_if
// Bundles the ID-side inputs and EX-side outputs of the ID/EX pipeline
// register.
//   master : decode/hazard side. Drives id_*, observes ex_*, mul_stall,
//            ex_mul_valid and the perf counters.
//   slave  : the stage register itself.
// Signals:
//   id_ctrl[9:0]   control word {jump,reg_write,alu_src,mem_write,mem_2_reg,
//                  mem_read,branch,reg_dst,alu_op[1:0]}
//   id_flush       flush_ID_EX request
//   id_hz_stall    load-use stall request
//   id_is_mul      decoded multiply
//   id_rs1_data/id_rs2_data/id_imm, id_rs1/id_rs2/id_rd   operands, indices
//   ex_*           registered copies presented to EX
//   mul_stall      freeze PC and IF/ID while a multiply occupies EX
//   ex_mul_valid   multiplier result valid this cycle
//   perf_bubble_cnt / perf_mul_cnt   perf counters (0 unless ID_EX_PERF_EN)
// ---------------------------------------------------------------------------
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 64
);
  logic [9:0]        id_ctrl;
  logic              id_flush;
  logic              id_hz_stall;
  logic              id_is_mul;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;

  logic [9:0]        ex_ctrl;
  logic              ex_is_mul;
  logic [DATA_W-1:0] ex_rs1_data;
  logic [DATA_W-1:0] ex_rs2_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic              mul_stall;
  logic              ex_mul_valid;
  logic [31:0]       perf_bubble_cnt;
  logic [31:0]       perf_mul_cnt;

  modport master (
    output id_ctrl, id_flush, id_hz_stall, id_is_mul,
           id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
    input  ex_ctrl, ex_is_mul, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, mul_stall, ex_mul_valid,
           perf_bubble_cnt, perf_mul_cnt
  );

  modport slave (
    input  id_ctrl, id_flush, id_hz_stall, id_is_mul,
           id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
    output ex_ctrl, ex_is_mul, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, mul_stall, ex_mul_valid,
           perf_bubble_cnt, perf_mul_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register for the 5-stage core with the multi-cycle
// multiplier. Captures the decode control word and operands every cycle,
// turns flush / load-use requests into bubbles, and parks a multiply in EX
// for MUL_LAT cycles while stalling PC and IF/ID.
// Ports:
//   clk      core clock, all state on rising edge
//   arst_n   synchronous active-low reset
//   bus      id_ex_stage_reg_if.slave (id_* in, ex_*/stall/perf out)
// Parameters:
//   DATA_W   operand / immediate width
//   MUL_LAT  cycles a multiply occupies EX (1..15)
// Optional feature macro: ID_EX_PERF_EN
//   defined   : 32-bit saturating bubble / hold counters
//   undefined : perf ports tied to 0, no counter flops
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W  = 64,
  parameter int MUL_LAT = 4
) (
  input logic              clk,
  input logic              arst_n,
  id_ex_stage_reg_if.slave bus
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
    $error("id_ex_stage_reg: MUL_LAT must be 1..15");
  end

  localparam logic [3:0] MCNT_LOAD = 4'(MUL_LAT - 1);

  logic [9:0]        ctrl_q;
  logic              is_mul_q;
  logic [DATA_W-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [3:0]        mcnt;

  // A nonzero counter means the multiply still owns EX: everything holds
  // and the flush/stall requests wait (ID is frozen, so they persist).
  logic hold, bubble;
  assign hold   = (mcnt != 4'd0);
  assign bubble = bus.id_flush | bus.id_hz_stall;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ctrl_q     <= '0;
      is_mul_q   <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      mcnt       <= '0;
    end else if (hold) begin
      mcnt <= mcnt - 4'd1;
    end else begin
      // Data/index fields follow ID in both bubble and capture; only the
      // control side distinguishes them.
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
      rs1_q      <= bus.id_rs1;
      rs2_q      <= bus.id_rs2;
      rd_q       <= bus.id_rd;
      if (bubble) begin
        ctrl_q   <= '0;
        is_mul_q <= 1'b0;
        mcnt     <= '0;
      end else begin
        ctrl_q   <= bus.id_ctrl;
        is_mul_q <= bus.id_is_mul;
        mcnt     <= bus.id_is_mul ? MCNT_LOAD : 4'd0;
      end
    end
  end

  assign bus.ex_ctrl      = ctrl_q;
  assign bus.ex_is_mul    = is_mul_q;
  assign bus.ex_rs1_data  = rs1_data_q;
  assign bus.ex_rs2_data  = rs2_data_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_rs1       = rs1_q;
  assign bus.ex_rs2       = rs2_q;
  assign bus.ex_rd        = rd_q;
  assign bus.mul_stall    = hold;
  // Result is ready on the last EX cycle of the multiply, i.e. once the
  // counter has drained (immediately for MUL_LAT=1).
  assign bus.ex_mul_valid = is_mul_q & ~hold;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, mul_cnt;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      bubble_cnt <= '0;
      mul_cnt    <= '0;
    end else begin
      if (!hold && bubble && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (hold && mul_cnt != 32'hFFFF_FFFF)
        mul_cnt <= mul_cnt + 32'd1;
    end
  end

  assign bus.perf_bubble_cnt = bubble_cnt;
  assign bus.perf_mul_cnt    = mul_cnt;
`else
  assign bus.perf_bubble_cnt = 32'd0;
  assign bus.perf_mul_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Directed steps from the test plan followed by randomized traffic, all
// checked against a cycle-count reference model: a multiply captured on
// cycle c owns EX through cycle c+MUL_LAT-1 and stalls while the current
// cycle is before that end point.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;
  localparam int DATA_W  = 64;
  localparam int MUL_LAT = 4;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_W(DATA_W)) bus ();

  id_ex_stage_reg #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  int          cyc = 0;
  int          mul_end = 0;
  logic [9:0]  m_ctrl;
  logic        m_is_mul;
  logic [63:0] m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        data_known;
  longint      m_pb, m_pm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    bit stall;
    stall = cyc < mul_end;
    chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ctrl));
    chk("ex_is_mul", 64'(bus.ex_is_mul), 64'(m_is_mul));
    chk("mul_stall", 64'(bus.mul_stall), 64'(stall));
    chk("ex_mul_valid", 64'(bus.ex_mul_valid), 64'(m_is_mul && !stall));
    if (data_known) begin
      chk("ex_rs1_data", bus.ex_rs1_data, m_rs1d);
      chk("ex_rs2_data", bus.ex_rs2_data, m_rs2d);
      chk("ex_imm", bus.ex_imm, m_imm);
      chk("ex_idx", 64'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd}), 64'({m_rs1, m_rs2, m_rd}));
    end
`ifdef ID_EX_PERF_EN
    chk("perf_bubble_cnt", 64'(bus.perf_bubble_cnt), 64'(m_pb > 64'hFFFFFFFF ? 64'hFFFFFFFF : m_pb));
    chk("perf_mul_cnt", 64'(bus.perf_mul_cnt), 64'(m_pm > 64'hFFFFFFFF ? 64'hFFFFFFFF : m_pm));
`else
    chk("perf_bubble_cnt", 64'(bus.perf_bubble_cnt), 64'd0);
    chk("perf_mul_cnt", 64'(bus.perf_mul_cnt), 64'd0);
`endif
  endtask

  // One clock edge: update the model from the inputs present before the
  // edge, then check #1 later.
  task automatic tick();
    bit stall_now;
    stall_now = cyc < mul_end;
    @(posedge clk);
    cyc++;
    if (!arst_n) begin
      m_ctrl = '0; m_is_mul = 0;
      m_rs1d = '0; m_rs2d = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0;
      data_known = 1; mul_end = cyc; m_pb = 0; m_pm = 0;
    end else if (stall_now) begin
      m_pm++;
    end else if (bus.id_flush || bus.id_hz_stall) begin
      m_ctrl = '0; m_is_mul = 0; data_known = 0; m_pb++;
    end else begin
      m_ctrl = bus.id_ctrl; m_is_mul = bus.id_is_mul;
      m_rs1d = bus.id_rs1_data; m_rs2d = bus.id_rs2_data; m_imm = bus.id_imm;
      m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2; m_rd = bus.id_rd;
      data_known = 1;
      mul_end = bus.id_is_mul ? cyc + MUL_LAT - 1 : cyc;
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic [9:0] ctrl, input logic fl, input logic hz,
                       input logic mul, input logic [63:0] d1, input logic [4:0] rd);
    bus.id_ctrl = ctrl; bus.id_flush = fl; bus.id_hz_stall = hz; bus.id_is_mul = mul;
    bus.id_rs1_data = d1; bus.id_rs2_data = d1 ^ 64'hA5A5; bus.id_imm = ~d1;
    bus.id_rs1 = rd + 5'd1; bus.id_rs2 = rd + 5'd2; bus.id_rd = rd;
  endtask

  initial begin
    logic [9:0] snap_ctrl;
    logic [63:0] snap_d;
    longint pb0;
    arst_n = 0;
    drive(10'h3FF, 0, 0, 1, 64'hFFFF, 5'd31);

    // reset, 2 cycles, with a busy control word on the input
    tick(); tick();
    chk("rst_ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    chk("rst_mul_stall", 64'(bus.mul_stall), 64'd0);
    arst_n = 1;

    // plain capture
    drive(10'h182, 0, 0, 0, 64'd5, 5'd7);
    tick();
    chk("cap_ctrl", 64'(bus.ex_ctrl), 64'h182);
    chk("cap_rs1_data", bus.ex_rs1_data, 64'd5);
    chk("cap_rd", 64'(bus.ex_rd), 64'd7);

    // multiply: captured at edge T, EX held through T+3
    drive(10'h133, 0, 0, 1, 64'h1234, 5'd9);
    tick();
    snap_ctrl = bus.ex_ctrl; snap_d = bus.ex_rs1_data;
    for (int i = 0; i < 3; i++) begin
      chk("mul_stall_hi", 64'(bus.mul_stall), 64'd1);
      chk("mul_valid_lo", 64'(bus.ex_mul_valid), 64'd0);
      drive(10'h3C3, 0, 0, 0, 64'hDEAD, 5'd3);   // ignored during hold
      tick();
      chk("mul_hold_ctrl", 64'(bus.ex_ctrl), 64'(snap_ctrl));
      chk("mul_hold_data", bus.ex_rs1_data, snap_d);
    end
    chk("mul_stall_end", 64'(bus.mul_stall), 64'd0);
    chk("mul_valid_end", 64'(bus.ex_mul_valid), 64'd1);

    // back-to-back multiply, then flush asserted during its stall
    drive(10'h155, 0, 0, 1, 64'h77, 5'd4);
    tick();
    chk("b2b_stall", 64'(bus.mul_stall), 64'd1);
    drive(10'h0FF, 1, 0, 0, 64'h88, 5'd5);
    tick(); tick(); tick();
    chk("flush_deferred_ctrl", 64'(bus.ex_ctrl), 64'h155);
    chk("flush_deferred_stall", 64'(bus.mul_stall), 64'd0);
    tick();
    chk("flush_applied", 64'(bus.ex_ctrl), 64'd0);

    // load-use bubble
    pb0 = m_pb;
    drive(10'h1B0, 0, 1, 1, 64'h99, 5'd6);
    tick();
    chk("hz_ctrl", 64'(bus.ex_ctrl), 64'd0);
    chk("hz_is_mul", 64'(bus.ex_is_mul), 64'd0);
    chk("hz_model_pb", 64'(m_pb - pb0), 64'd1);

    // flush + hz together: single bubble
    drive(10'h1B0, 1, 1, 0, 64'h9A, 5'd6);
    tick();
    chk("both_ctrl", 64'(bus.ex_ctrl), 64'd0);

    // reset during the second cycle of a multiply
    drive(10'h121, 0, 0, 1, 64'h55, 5'd8);
    tick();
    arst_n = 0;
    tick();
    chk("rst_mid_stall", 64'(bus.mul_stall), 64'd0);
    chk("rst_mid_is_mul", 64'(bus.ex_is_mul), 64'd0);
    arst_n = 1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive(10'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, {$urandom, $urandom}, 5'($urandom));
      arst_n = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
